// File: rtl/addr_unit_scheduler.sv
// Round-robin issue scheduler for the shared load/store address unit.
// Optional watchdog on the unit confirm is built with `define ADDR_SCHED_TIMEOUT_EN.
module addr_unit_scheduler #(
    parameter int       N_RS    = 4,
    parameter logic [3:0] ID_BASE = 4'd0,
    parameter int       TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [N_RS-1:0]       rs_ready,
    input  logic [16*N_RS-1:0]    rs_offset,
    input  logic [16*N_RS-1:0]    rs_base,
    input  logic [16*N_RS-1:0]    rs_sdata,
    input  logic [6*N_RS-1:0]     rs_op_rd,
    output logic [N_RS-1:0]       rs_grant,
    output logic [N_RS-1:0]       rs_release,
    output logic                  au_start,
    output logic [3:0]            au_id,
    output logic [15:0]           au_dado1,
    output logic [15:0]           au_dado2,
    output logic [15:0]           au_dado3,
    output logic [5:0]            au_op_rd,
    input  logic                  au_busy,
    input  logic                  au_confirm,
    input  logic [22:0]           au_result,
    output logic                  au_finalize,
    output logic                  cdb_req,
    output logic [22:0]           cdb_data,
    input  logic                  cdb_ack,
    output logic                  sched_err
);

    // state     | meaning
    // IDLE      | waiting for a ready station while the unit is free
    // ISSUE     | start/grant pulse, command driven to the unit
    // WAIT_CONF | waiting for the unit result
    // BCAST     | result held on the CDB until acknowledged
    // DONE      | finalize/release pulse, pointer advances
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CONF, BCAST, DONE} state_t;

    localparam int IW = (N_RS > 1) ? $clog2(N_RS) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          found;
    logic          launch;
    logic          timed_out;

    always_comb begin
        int c;
        c     = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_RS; k++) begin
            c = (int'(ptr) + k) % N_RS;
            if (!found && rs_ready[IW'(c)]) begin
                found = 1'b1;
                sel   = IW'(c);
            end
        end
    end

`ifdef ADDR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Loaded while issuing so the terminal count lands after TIMEOUT waiting cycles.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            tmo_cnt   <= '0;
            sched_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= TW'(TIMEOUT - 1);
            else if (state == WAIT_CONF && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
            if (timed_out)
                sched_err <= 1'b1;
        end
    end

    assign timed_out = (state == WAIT_CONF) && !au_confirm && (tmo_cnt == '0);
`else
    assign timed_out = 1'b0;
    assign sched_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (found && !au_busy) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_CONF;
            WAIT_CONF: begin
                if (au_confirm)     state_nx = BCAST;
                else if (timed_out) state_nx = DONE;
            end
            BCAST:     if (cdb_ack && cdb_req) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    assign launch = (state == IDLE) && (state_nx == ISSUE);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ptr         <= '0;
            idx         <= '0;
            au_start    <= 1'b0;
            rs_grant    <= '0;
            rs_release  <= '0;
            au_id       <= '0;
            au_dado1    <= '0;
            au_dado2    <= '0;
            au_dado3    <= '0;
            au_op_rd    <= '0;
            au_finalize <= 1'b0;
            cdb_req     <= 1'b0;
            cdb_data    <= '0;
        end else begin
            au_start    <= launch;
            rs_grant    <= launch ? (N_RS'(1) << sel) : '0;
            cdb_req     <= (state_nx == BCAST);
            au_finalize <= (state_nx == DONE);
            rs_release  <= (state_nx == DONE) ? (N_RS'(1) << idx) : '0;
            // Operand registers double as the command outputs and hold until the next launch.
            if (launch) begin
                idx      <= sel;
                au_id    <= ID_BASE + 4'(sel);
                au_dado1 <= rs_offset[16*sel +: 16];
                au_dado2 <= rs_base[16*sel +: 16];
                au_dado3 <= rs_sdata[16*sel +: 16];
                au_op_rd <= rs_op_rd[6*sel +: 6];
            end
            if (state == WAIT_CONF && au_confirm)
                cdb_data <= au_result;
            if (state == DONE)
                ptr <= (idx == IW'(N_RS - 1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: doc/addr_unit_scheduler.md
# addr_unit_scheduler

Issue scheduler and sequencer for the shared load/store address arithmetic unit. It arbitrates round-robin among N_RS load/store reservation stations with ready operands and drives one station's operands into the address unit. It captures the unit's 23-bit result, holds it on the CDB request interface until acknowledged, then pulses the unit's finalize input and releases the originating station. It sits between the load/store reservation stations, the address unit and the CDB arbiter.

## Interface
- N_RS, 4: number of load/store reservation stations (1..16)
- ID_BASE, 4'd0: station ID of index 0; au_id = ID_BASE + index (mod 16)
- TIMEOUT, 15: watchdog limit in cycles (only with ADDR_SCHED_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- rs_ready  in  N_RS  station i has valid offset, base and store data
- rs_offset  in  16*N_RS  offset of station i at bits [16i+15:16i]
- rs_base  in  16*N_RS  base address of station i
- rs_sdata  in  16*N_RS  store data of station i
- rs_op_rd  in  6*N_RS  opcode/destination of station i at [6i+5:6i]
- rs_grant  out  N_RS  one-hot, 1-cycle pulse: station dispatched
- rs_release  out  N_RS  one-hot, 1-cycle pulse: station may free its entry
- au_start, au_id[3:0], au_dado1/2/3[15:0], au_op_rd[5:0]  out  unit command (dado1 = offset, dado2 = base, dado3 = store data)
- au_busy  in  1  unit busy
- au_confirm  in  1  unit result valid
- au_result  in  23  [22:20] Rd, [19:16] station ID, [15:0] address
- au_finalize  out  1  1-cycle pulse: unit may return to idle
- cdb_req  out  1  result pending on the CDB
- cdb_data  out  23  captured au_result
- cdb_ack  in  1  CDB accepted cdb_data
- sched_err  out  1  sticky watchdog error

## Operation
- All outputs registered. Reset value of every output is 0; the round-robin pointer, the latched index and the operand registers reset to 0.
- FSM states: IDLE, ISSUE, WAIT_CONF, BCAST, DONE.
- IDLE: if (rs_ready != 0) and !au_busy, select the first ready index at or after the pointer, wrapping modulo N_RS. Latch the index and that station's operands, then go to ISSUE.
- ISSUE: assert au_start and rs_grant[idx] for one cycle and drive the latched command, then go to WAIT_CONF. Command outputs hold their values until the next ISSUE.
- WAIT_CONF: when au_confirm = 1, capture au_result into cdb_data and go to BCAST.
- BCAST: hold cdb_req = 1 and cdb_data stable. When cdb_ack = 1 and cdb_req = 1, go to DONE. cdb_ack is ignored in every other state.
- DONE: pulse au_finalize and rs_release[idx], set the pointer to (idx+1) mod N_RS, then go to IDLE.
- The in-flight index is not re-selected before DONE. Changes to rs_ready or operands after latching do not affect the issued command.
- Simultaneous requests: exactly one grant. Rotation prevents starvation; each ready station is served within N_RS operations.
- CLR mid-operation: the FSM returns to IDLE immediately and all outputs clear. No release pulse is issued for the aborted operation.

## Timing
- Request seen in IDLE at cycle 0:
  - cycle 1: au_start and grant
  - cycle 2: au_confirm expected
  - cycle 3: cdb_req
  - cycle 4 (with cdb_ack in cycle 3): au_finalize and release
  - cycle 5: IDLE again
- Minimum 5 cycles per operation; each cycle of cdb_ack delay adds one cycle.
- The scheduler never asserts au_start while au_busy = 1 or while outside IDLE→ISSUE.

## Configuration
- ADDR_SCHED_TIMEOUT_EN defined: a counter runs in WAIT_CONF. If au_confirm has not arrived after TIMEOUT cycles:
  - set sched_err (sticky until CLR)
  - pulse au_finalize and rs_release[idx]
  - leave cdb_req low and return to IDLE
- ADDR_SCHED_TIMEOUT_EN undefined: no counter is built, WAIT_CONF waits indefinitely, and sched_err is tied 0.

## Test plan
- Single request, N_RS=4, ID_BASE=4: rs_ready=0001, offset 0x0010, base 0x1000, cdb_ack tied 1.
  - Expect au_start with au_id=4, dado1=0x0010, dado2=0x1000 in cycle 1.
  - Expect cdb_data[15:0]=0x1010 with cdb_req in cycle 3.
  - Expect au_finalize and rs_release=0001 in cycle 4.
- Round-robin: rs_ready=1111 held for 5 operations → grants 0001, 0010, 0100, 1000, 0001.
- CDB backpressure: cdb_ack low for 3 cycles → cdb_req and cdb_data stable; finalize one cycle after ack; total 8 cycles.
- au_busy held 1 with rs_ready=0010 → no au_start, no grant; au_busy drop → ISSUE next cycle.
- CLR asserted in BCAST → all outputs 0 in the same cycle; the next request is served from pointer 0.
- With ADDR_SCHED_TIMEOUT_EN and au_confirm held 0 → after 15 cycles: sched_err=1, au_finalize pulse, no cdb_req.
